soc_event_prio_arbiter: RTL and testbench

Parametrised successor to the SoC event arbiter. It selects one pending SoC event per transaction using strict priority across configurable levels and round-robin fairness within each level, with a per-event enable mask. The chosen grant is registered and presented on a valid/ready handshake to the event dispatcher, which feeds the FC event unit and the uDMA/timer event routing.

---
 rtl/soc_event_arb_pkg.sv | 25 ++
 rtl/soc_event_rr_pick.sv | 40 ++++
 rtl/soc_event_prio_arbiter.sv | 142 ++++++++++++++
 tb/tb_soc_event_prio_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/soc_event_arb_pkg.sv
// Shared definitions for the SoC event priority arbiter.
package soc_event_arb_pkg;

    localparam int unsigned EvntNumDefault  = 256;
    localparam int unsigned PrioLvlsDefault = 4;

    // Widest one-hot vector onehot_to_idx accepts; narrower vectors are zero-extended.
    localparam int unsigned OhMaxW = 1024;

    // Bit width needed to encode n values, never less than 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Encoded index of a one-hot vector (OR of set-bit positions; 0 for an empty vector).
    function automatic int unsigned onehot_to_idx(input logic [OhMaxW-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < OhMaxW; i++) begin
            if (vec[i]) idx |= i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/soc_event_rr_pick.sv
// Round-robin first-set search: lowest set bit at or above ptr_i, wrapping to 0.
module soc_event_rr_pick
    import soc_event_arb_pkg::*;
#(
    parameter int unsigned N     = EvntNumDefault,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     vec_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0]   therm;
    logic [2*N-1:0] dbl;

    // Thermometer mask: ones at and above the pointer.
    always_comb begin
        therm = '0;
        for (int unsigned i = 0; i < N; i++) begin
            therm[i] = (i >= 32'(ptr_i));
        end
    end

    // Lower half holds the at-or-above-pointer candidates, upper half the wrapped ones.
    assign dbl = {vec_i, vec_i & therm};

    // Lowest set bit of the double-width vector; downward scan lets the lowest win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned j = 2 * N; j > 0; j--) begin
            if (dbl[j-1]) begin
                found_o = 1'b1;
                idx_o   = (j - 1 >= N) ? IDX_W'(j - 1 - N) : IDX_W'(j - 1);
            end
        end
    end

endmodule

// File: rtl/soc_event_prio_arbiter.sv
// Strict-priority event arbiter with per-level round-robin and a registered valid/ready grant.
module soc_event_prio_arbiter
    import soc_event_arb_pkg::*;
#(
    parameter int unsigned EVNT_NUM  = EvntNumDefault,
    parameter int unsigned PRIO_LVLS = PrioLvlsDefault,
    parameter int unsigned IDX_W     = clog2_min1(EVNT_NUM),
    parameter int unsigned PL_W      = clog2_min1(PRIO_LVLS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [EVNT_NUM-1:0]      req_i,
    input  logic [EVNT_NUM-1:0]      mask_i,
    input  logic [EVNT_NUM*PL_W-1:0] prio_i,
    output logic                     gnt_valid_o,
    input  logic                     gnt_ready_i,
    output logic [EVNT_NUM-1:0]      gnt_o,
    output logic [IDX_W-1:0]         gnt_idx_o,
    output logic [PL_W-1:0]          gnt_prio_o,
    output logic                     any_req_o
);

    logic [EVNT_NUM-1:0][PL_W-1:0]   prio_c;
    logic [EVNT_NUM-1:0]             excl;
    logic [EVNT_NUM-1:0]             elig;
    logic [EVNT_NUM-1:0]             lvl_vec;
    logic [PL_W-1:0]                 lvl;
    logic [PRIO_LVLS-1:0][IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0]                ptr_sel;
    logic [IDX_W-1:0]                ptr_nxt;
    logic                            pick_found;
    logic [IDX_W-1:0]                pick_idx;
    logic                            load;

    logic                gnt_valid_q, gnt_valid_d;
    logic [EVNT_NUM-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [PL_W-1:0]     gnt_prio_q, gnt_prio_d;

    // Clamp out-of-range priority fields to the top level.
    always_comb begin
        prio_c = '0;
        for (int unsigned k = 0; k < EVNT_NUM; k++) begin
            prio_c[k] = (32'(prio_i[k*PL_W +: PL_W]) >= PRIO_LVLS) ?
                        PL_W'(PRIO_LVLS - 1) : prio_i[k*PL_W +: PL_W];
        end
    end

    // An event whose grant is being accepted this cycle may not be re-granted at once.
    assign excl      = (gnt_valid_q && gnt_ready_i) ? gnt_q : '0;
    assign elig      = req_i & mask_i & ~excl;
    assign any_req_o = |(req_i & mask_i);

    // Highest priority level present among eligible events.
    always_comb begin
        lvl = '0;
        for (int unsigned k = 0; k < EVNT_NUM; k++) begin
            if (elig[k] && (prio_c[k] > lvl)) lvl = prio_c[k];
        end
    end

    // Eligible events at the winning level.
    always_comb begin
        lvl_vec = '0;
        for (int unsigned k = 0; k < EVNT_NUM; k++) begin
            lvl_vec[k] = elig[k] && (prio_c[k] == lvl);
        end
    end

    // Select the round-robin pointer of the winning level.
    always_comb begin
        ptr_sel = '0;
        for (int unsigned l = 0; l < PRIO_LVLS; l++) begin
            if (PL_W'(l) == lvl) ptr_sel = ptr_q[l];
        end
    end

    soc_event_rr_pick #(
        .N     (EVNT_NUM),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec_i   (lvl_vec),
        .ptr_i   (ptr_sel),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // pick_found is set exactly when any event is eligible.
    assign load    = (~gnt_valid_q | gnt_ready_i) & pick_found;
    assign ptr_nxt = (pick_idx == IDX_W'(EVNT_NUM - 1)) ? '0 : pick_idx + 1'b1;

    // Advance only the winning level's pointer, and only when a grant is loaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (load) begin
            for (int unsigned l = 0; l < PRIO_LVLS; l++) begin
                if (PL_W'(l) == lvl) ptr_q[l] <= ptr_nxt;
            end
        end
    end

    // Output register next state: load, drain on accept, or hold while stalled.
    always_comb begin
        gnt_valid_d = gnt_valid_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_prio_d  = gnt_prio_q;
        if (load) begin
            gnt_valid_d = 1'b1;
            gnt_d       = EVNT_NUM'(1) << pick_idx;
            gnt_idx_d   = pick_idx;
            gnt_prio_d  = lvl;
        end else if (gnt_valid_q && gnt_ready_i) begin
            gnt_valid_d = 1'b0;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_prio_d  = '0;
        end
    end

    // Registered grant outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_valid_q <= 1'b0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_prio_q  <= '0;
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_prio_q  <= gnt_prio_d;
        end
    end

    assign gnt_valid_o = gnt_valid_q;
    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_prio_o  = gnt_prio_q;

endmodule

// File: tb/tb_soc_event_prio_arbiter.sv
// Directed bench for soc_event_prio_arbiter with EVNT_NUM=8, PRIO_LVLS=4.
module tb_soc_event_prio_arbiter;
    import soc_event_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  mask;
    logic [15:0] prio;
    logic        gnt_valid;
    logic        ready;
    logic [7:0]  gnt;
    logic [2:0]  gnt_idx;
    logic [1:0]  gnt_prio;
    logic        any_req;

    int unsigned n_chk;
    int unsigned n_pass;

    soc_event_prio_arbiter #(
        .EVNT_NUM  (8),
        .PRIO_LVLS (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .mask_i      (mask),
        .prio_i      (prio),
        .gnt_valid_o (gnt_valid),
        .gnt_ready_i (ready),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_prio_o  (gnt_prio),
        .any_req_o   (any_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input int unsigned idx, input int unsigned pl);
        chk({tag, "_valid"}, 32'(gnt_valid), 32'd1);
        chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        chk({tag, "_oh"}, 32'(gnt), 32'd1 << idx);
        chk({tag, "_prio"}, 32'(gnt_prio), 32'(pl));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_oh"}, 32'(gnt), 32'd0);
        chk({tag, "_idx"}, 32'(gnt_idx), 32'd0);
        chk({tag, "_prio"}, 32'(gnt_prio), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        req    = 8'h00;
        mask   = 8'h00;
        prio   = 16'h0000;
        ready  = 1'b0;

        // Reset state
        tick();
        tick();
        chk_empty("rst");
        chk("rst_any", 32'(any_req), 32'd0);
        rst = 1'b0;

        // 1: all requesting at level 0, continuous ready -> 0..7 then 0
        mask  = 8'hFF;
        req   = 8'hFF;
        ready = 1'b1;
        #1;
        chk("t1_any", 32'(any_req), 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_grant("t1", i % 8, 0);
            chk("t1_dec", onehot_to_idx(OhMaxW'(gnt)), 32'(i % 8));
        end

        // 2: prio[4]=1, prio[7]=3; exclusion alternates 7 and 4
        req  = 8'h90;
        prio = 16'hC100;
        tick();
        chk_grant("t2a", 7, 3);
        tick();
        chk_grant("t2b", 4, 1);
        tick();
        chk_grant("t2c", 7, 3);
        req = 8'h10;
        tick();
        chk_grant("t2d", 4, 1);

        // Drain: accept with nothing eligible clears the outputs
        req = 8'h00;
        tick();
        chk_empty("drain");

        // 3: fresh pointers, stall with req=0x05
        rst = 1'b1;
        #2;
        rst  = 1'b0;
        prio = 16'h0000;
        req  = 8'h05;
        ready = 1'b0;
        tick();
        chk_grant("t3_load", 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_grant("t3_stall", 0, 0);
        end
        req = 8'h04;
        tick();
        chk_grant("t3_drop", 0, 0);
        ready = 1'b1;
        tick();
        chk_grant("t3_next", 2, 0);

        // 4: lone requester 3 -> grant, bubble, grant
        req = 8'h08;
        tick();
        chk_grant("t4a", 3, 0);
        tick();
        chk_empty("t4_bubble");
        tick();
        chk_grant("t4b", 3, 0);

        // 5: mask limits grants to 0..3
        req  = 8'hFF;
        mask = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_grant("t5", i % 4, 0);
        end
        req = 8'hF0;
        #1;
        chk("t5_any", 32'(any_req), 32'd0);
        tick();
        chk_empty("t5_none");

        // 6: two levels interleaved, level-0 pointer untouched, reset mid-stall
        rst = 1'b1;
        #2;
        rst  = 1'b0;
        mask = 8'hFF;
        prio = 16'h0808;
        req  = 8'h2B;
        tick();
        chk_grant("t6a", 1, 2);
        tick();
        chk_grant("t6b", 5, 2);
        tick();
        chk_grant("t6c", 1, 2);
        req = 8'h09;
        tick();
        chk_grant("t6_l0", 0, 0);
        ready = 1'b0;
        tick();
        chk_grant("t6_stall", 0, 0);
        rst = 1'b1;
        #1;
        chk_empty("t6_async");
        #1;
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        chk_grant("t6_r0", 0, 0);
        req = 8'h22;
        tick();
        chk_grant("t6_r2", 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
